// File: rtl/mips_multicycle_sequencer_if.sv
// Memory-port bundle between the multi-cycle sequencer and the unified
// instruction/data memory.
interface mips_multicycle_sequencer_if;
    // Handshake: an access is in flight in every cycle mem_req is high; it
    // completes in the cycle mem_ready is also high. mem_we and iord are
    // valid only while mem_req is high. mem_ready means nothing without mem_req.
    logic mem_req;
    logic mem_we;
    logic iord;
    logic mem_ready;

    modport master (
        output mem_req,
        output mem_we,
        output iord,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  iord,
        output mem_ready
    );
endinterface

// File: rtl/mips_multicycle_sequencer.sv
// Multi-cycle MIPS control FSM: steps the shared datapath through
// fetch/decode/execute/memory/writeback and guards memory waits with a watchdog.
module mips_multicycle_sequencer #(
    parameter int unsigned WAIT_LIMIT = 255
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [5:0]                         opcode,
    input  logic [5:0]                         funct,
    input  logic                               zero,
    mips_multicycle_sequencer_if.master        mem,
    output logic                               ir_write,
    output logic                               pc_write,
    output logic [1:0]                         pc_src,
    output logic                               alu_src_a,
    output logic [1:0]                         alu_src_b,
    output logic [3:0]                         alu_control,
    output logic                               reg_write,
    output logic [1:0]                         reg_dst,
    output logic [1:0]                         mem_to_reg,
    output logic [3:0]                         state,
    output logic                               instr_done,
    output logic                               fault
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_RTEXE  = 4'd6,
        S_RTWB   = 4'd7,
        S_ITEXE  = 4'd8,
        S_ITWB   = 4'd9,
        S_BRANCH = 4'd10,
        S_JUMP   = 4'd11,
        S_JR     = 4'd12,
        S_JAL    = 4'd13,
        S_RSVD   = 4'd14,
        S_FAULT  = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;
    localparam logic [3:0] ALU_NOR  = 4'b1010;
    localparam logic [3:0] ALU_SLLV = 4'b1011;
    localparam logic [3:0] ALU_SRLV = 4'b1100;
    localparam logic [3:0] ALU_SRAV = 4'b1101;
    localparam logic [3:0] ALU_LUI  = 4'b1110;

    // Returns {legal, alu_code} for an R-type funct (JR is handled separately).
    function automatic logic [4:0] rtype_decode(input logic [5:0] f);
        case (f)
            6'b100000, 6'b100001: rtype_decode = {1'b1, ALU_ADD};
            6'b100010, 6'b100011: rtype_decode = {1'b1, ALU_SUB};
            6'b100100:            rtype_decode = {1'b1, ALU_AND};
            6'b100101:            rtype_decode = {1'b1, ALU_OR};
            6'b100110:            rtype_decode = {1'b1, ALU_XOR};
            6'b100111:            rtype_decode = {1'b1, ALU_NOR};
            6'b101010:            rtype_decode = {1'b1, ALU_SLT};
            6'b101011:            rtype_decode = {1'b1, ALU_SLTU};
            6'b000000:            rtype_decode = {1'b1, ALU_SLL};
            6'b000010:            rtype_decode = {1'b1, ALU_SRL};
            6'b000011:            rtype_decode = {1'b1, ALU_SRA};
            6'b000100:            rtype_decode = {1'b1, ALU_SLLV};
            6'b000110:            rtype_decode = {1'b1, ALU_SRLV};
            6'b000111:            rtype_decode = {1'b1, ALU_SRAV};
            default:              rtype_decode = {1'b0, ALU_ADD};
        endcase
    endfunction

    function automatic logic [3:0] itype_alu(input logic [5:0] op);
        case (op)
            OP_ANDI:  itype_alu = ALU_AND;
            OP_ORI:   itype_alu = ALU_OR;
            OP_XORI:  itype_alu = ALU_XOR;
            OP_SLTI:  itype_alu = ALU_SLT;
            OP_SLTIU: itype_alu = ALU_SLTU;
            OP_LUI:   itype_alu = ALU_LUI;
            default:  itype_alu = ALU_ADD;
        endcase
    endfunction

    state_t     state_q;
    state_t     state_d;
    logic [7:0] wait_q;
    logic [7:0] wait_d;
    logic       req_state;
    logic       waiting;
    logic       wait_expire;
    logic [4:0] rt_dec;

    logic       mem_req_c;
    logic       mem_we_c;
    logic       iord_c;
    logic       ir_write_c;
    logic       pc_write_c;
    logic [1:0] pc_src_c;
    logic       alu_src_a_c;
    logic [1:0] alu_src_b_c;
    logic [3:0] alu_control_c;
    logic       reg_write_c;
    logic [1:0] reg_dst_c;
    logic [1:0] mem_to_reg_c;
    logic       instr_done_c;
    logic       fault_c;

    assign rt_dec    = rtype_decode(funct);
    assign req_state = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
    assign waiting   = req_state && !mem.mem_ready;
    // The limit cycle is the one whose wait would bring the count to WAIT_LIMIT.
    assign wait_expire = waiting && (({1'b0, wait_q} + 9'd1) == 9'(WAIT_LIMIT));
    // Leaving a request state always means the access completed, so the count
    // is naturally zero on entry to the next request state.
    assign wait_d = waiting ? (wait_q + 8'd1) : 8'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            wait_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        mem_req_c     = 1'b0;
        mem_we_c      = 1'b0;
        iord_c        = 1'b0;
        ir_write_c    = 1'b0;
        pc_write_c    = 1'b0;
        pc_src_c      = 2'b00;
        alu_src_a_c   = 1'b0;
        alu_src_b_c   = 2'b00;
        alu_control_c = ALU_ADD;
        reg_write_c   = 1'b0;
        reg_dst_c     = 2'b00;
        mem_to_reg_c  = 2'b00;
        instr_done_c  = 1'b0;
        fault_c       = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_req_c = 1'b1;
                if (mem.mem_ready) begin
                    ir_write_c  = 1'b1;
                    pc_write_c  = 1'b1;
                    alu_src_b_c = 2'b01;
                    state_d     = S_DECODE;
                end else if (wait_expire) begin
                    state_d = S_FAULT;
                end
            end
            S_DECODE: begin
                alu_src_b_c = 2'b11;
                case (opcode)
                    OP_RTYPE: begin
                        if (funct == FN_JR)  state_d = S_JR;
                        else if (rt_dec[4])  state_d = S_RTEXE;
                        else                 state_d = S_FAULT;
                    end
                    OP_LW, OP_SW:   state_d = S_MEMADR;
                    OP_BEQ, OP_BNE: state_d = S_BRANCH;
                    OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI,
                    OP_XORI, OP_SLTI, OP_SLTIU, OP_LUI:
                                    state_d = S_ITEXE;
                    OP_J:           state_d = S_JUMP;
                    OP_JAL:         state_d = S_JAL;
                    default:        state_d = S_FAULT;
                endcase
            end
            S_MEMADR: begin
                alu_src_a_c = 1'b1;
                alu_src_b_c = 2'b10;
                state_d     = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                mem_req_c = 1'b1;
                iord_c    = 1'b1;
                if (mem.mem_ready)    state_d = S_MEMWB;
                else if (wait_expire) state_d = S_FAULT;
            end
            S_MEMWR: begin
                mem_req_c = 1'b1;
                mem_we_c  = 1'b1;
                iord_c    = 1'b1;
                if (mem.mem_ready) begin
                    instr_done_c = 1'b1;
                    state_d      = S_FETCH;
                end else if (wait_expire) begin
                    state_d = S_FAULT;
                end
            end
            S_MEMWB: begin
                reg_write_c  = 1'b1;
                mem_to_reg_c = 2'b01;
                instr_done_c = 1'b1;
                state_d      = S_FETCH;
            end
            S_RTEXE: begin
                alu_src_a_c   = 1'b1;
                alu_control_c = rt_dec[3:0];
                state_d       = S_RTWB;
            end
            S_RTWB: begin
                reg_write_c  = 1'b1;
                reg_dst_c    = 2'b01;
                instr_done_c = 1'b1;
                state_d      = S_FETCH;
            end
            S_ITEXE: begin
                alu_src_a_c   = 1'b1;
                alu_src_b_c   = 2'b10;
                alu_control_c = itype_alu(opcode);
                state_d       = S_ITWB;
            end
            S_ITWB: begin
                reg_write_c  = 1'b1;
                instr_done_c = 1'b1;
                state_d      = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a_c   = 1'b1;
                alu_control_c = ALU_SUB;
                pc_src_c      = 2'b01;
                pc_write_c    = (opcode == OP_BNE) ? !zero : zero;
                instr_done_c  = 1'b1;
                state_d       = S_FETCH;
            end
            S_JUMP: begin
                pc_write_c   = 1'b1;
                pc_src_c     = 2'b10;
                instr_done_c = 1'b1;
                state_d      = S_FETCH;
            end
            S_JR: begin
                pc_write_c   = 1'b1;
                pc_src_c     = 2'b11;
                instr_done_c = 1'b1;
                state_d      = S_FETCH;
            end
            S_JAL: begin
                // $31 takes the PC+4 written back in FETCH while PC loads the target.
                pc_write_c   = 1'b1;
                pc_src_c     = 2'b10;
                reg_write_c  = 1'b1;
                reg_dst_c    = 2'b10;
                mem_to_reg_c = 2'b10;
                instr_done_c = 1'b1;
                state_d      = S_FETCH;
            end
            S_FAULT: begin
                fault_c = 1'b1;
                state_d = S_FAULT;
            end
            default: state_d = S_FAULT;
        endcase
    end

    // Everything is held at zero while reset is asserted so no strobe escapes.
    assign mem.mem_req  = rst_n & mem_req_c;
    assign mem.mem_we   = rst_n & mem_we_c;
    assign mem.iord     = rst_n & iord_c;
    assign ir_write     = rst_n & ir_write_c;
    assign pc_write     = rst_n & pc_write_c;
    assign pc_src       = rst_n ? pc_src_c : 2'b00;
    assign alu_src_a    = rst_n & alu_src_a_c;
    assign alu_src_b    = rst_n ? alu_src_b_c : 2'b00;
    assign alu_control  = rst_n ? alu_control_c : 4'b0000;
    assign reg_write    = rst_n & reg_write_c;
    assign reg_dst      = rst_n ? reg_dst_c : 2'b00;
    assign mem_to_reg   = rst_n ? mem_to_reg_c : 2'b00;
    assign state        = rst_n ? state_q : 4'd0;
    assign instr_done   = rst_n & instr_done_c;
    assign fault        = rst_n & fault_c;

endmodule

// File: doc/mips_multicycle_sequencer.md
# mips_multicycle_sequencer

Multi-cycle control FSM that sequences the shared MIPS datapath: one ALU, one unified instruction/data memory port, register file, and PC/IR/MDR/A/B/ALUOut registers. Every instruction is broken into FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK steps, with a ready handshake on the memory port. It replaces the single-cycle decoder wherever the datapath is time-shared. ALU operation codes match the existing ALU.

## Interface
Parameters:
- WAIT_LIMIT, 255: maximum cycles `mem_req` may stay high without `mem_ready` before the sequencer faults (1..255).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  one clock; reset is asynchronous and active-low
- opcode  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag (combinational, current cycle)
- mem_ready  in  1  memory completes the access this cycle
- mem_req  out  1  memory access request
- mem_we  out  1  write strobe, valid with mem_req
- iord  out  1  address select: 0 = PC, 1 = ALUOut
- ir_write  out  1  load IR (and MDR) from read data
- pc_write  out  1  load PC
- pc_src  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = A (rs)
- alu_src_a  out  1  0 = PC, 1 = A
- alu_src_b  out  2  00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2
- alu_control  out  4  0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLL, 0110 SRL, 0111 SRA, 1000 SLT, 1001 SLTU, 1010 NOR, 1011 SLLV, 1100 SRLV, 1101 SRAV, 1110 LUI
- reg_write  out  1  register file write enable
- reg_dst  out  2  00 = rt, 01 = rd, 10 = $31
- mem_to_reg  out  2  00 = ALUOut, 01 = MDR, 10 = PC
- state  out  4  current state code
- instr_done  out  1  one-cycle pulse on the retiring cycle
- fault  out  1  high while in FAULT

## Operation
State codes:
- 0 FETCH, 1 DECODE, 2 MEMADR, 3 MEMRD, 4 MEMWB, 5 MEMWR, 6 RTEXE, 7 RTWB, 8 ITEXE, 9 ITWB, 10 BRANCH, 11 JUMP, 12 JR, 13 JAL, 15 FAULT.
- Code 14 is unused and returns to FAULT on the next edge.

Per-state actions (any output not listed is 0):
- **FETCH:** mem_req=1, iord=0.
  - If mem_ready: ir_write=1, pc_write=1, alu_src_a=0, alu_src_b=01, ADD, pc_src=00, then go to DECODE.
  - Otherwise stay in FETCH.
- **DECODE:** alu_src_a=0, alu_src_b=11, ADD (branch target into ALUOut). Next state by opcode:
  - 000000 with funct 001000 → JR.
  - 000000 with any other listed funct → RTEXE.
  - 100011 or 101011 → MEMADR.
  - 000100 or 000101 → BRANCH.
  - 001000, 001001, 001100, 001101, 001110, 001010, 001011, 001111 → ITEXE.
  - 000010 → JUMP.
  - 000011 → JAL.
  - Anything else, including an unlisted R-type funct → FAULT.
- **MEMADR:** alu_src_a=1, alu_src_b=10, ADD. Go to MEMRD for LW, MEMWR for SW.
- **MEMRD:** mem_req=1, iord=1. Go to MEMWB on mem_ready.
- **MEMWR:** mem_req=1, mem_we=1, iord=1. On mem_ready: instr_done=1, go to FETCH.
- **MEMWB:** reg_write=1, reg_dst=00, mem_to_reg=01, instr_done=1, go to FETCH.
- **RTEXE:** alu_src_a=1, alu_src_b=00, alu_control from funct:
  - ADD/ADDU → 0000, SUB/SUBU → 0001, AND → 0010, OR → 0011, XOR → 0100, NOR → 1010.
  - SLT → 1000, SLTU → 1001.
  - SLL → 0101, SRL → 0110, SRA → 0111, SLLV → 1011, SRLV → 1100, SRAV → 1101.
- **RTWB:** reg_write=1, reg_dst=01, mem_to_reg=00, instr_done=1.
- **ITEXE:** alu_src_a=1, alu_src_b=10, alu_control from opcode:
  - ADDI/ADDIU → 0000, ANDI → 0010, ORI → 0011, XORI → 0100.
  - SLTI → 1000, SLTIU → 1001, LUI → 1110.
- **ITWB:** reg_write=1, reg_dst=00, mem_to_reg=00, instr_done=1.
- **BRANCH:** alu_src_a=1, alu_src_b=00, SUB, pc_src=01, instr_done=1.
  - pc_write = zero for BEQ, ~zero for BNE.
- **JUMP:** pc_write=1, pc_src=10, instr_done=1.
- **JR:** pc_write=1, pc_src=11, instr_done=1.
- **JAL:** pc_write=1, pc_src=10, reg_write=1, reg_dst=10, mem_to_reg=10, instr_done=1.
  - The register file captures the PC value already incremented to PC+4 in FETCH, on the same edge the PC is overwritten.
- After every *WB, BRANCH, JUMP, JR and JAL state, the next state is FETCH.
- **FAULT:** all outputs 0 except fault=1 and state=15. Only rst_n leaves FAULT.

Wait watchdog:
- An 8-bit counter clears on entry to FETCH, MEMRD and MEMWR.
- It increments each cycle with mem_req=1 and mem_ready=0.
- When it reaches WAIT_LIMIT with mem_ready still 0, the next state is FAULT.
- mem_ready=1 in the limit cycle wins: the access completes normally.

## Timing
- rst_n low: state is forced to FETCH asynchronously, and every output is forced to 0 (mem_req included) until rst_n is high.
- mem_req asserts in the first cycle after reset release.
- A reset mid-instruction abandons it; no write strobe is issued after rst_n falls.
- Outputs are combinational from state, plus mem_ready in FETCH, MEMRD and MEMWR, plus zero in BRANCH.
- Latency with zero-wait memory (mem_ready high in the first request cycle):
  - BEQ/BNE/J/JR/JAL: 3 cycles.
  - R-type, I-type, SW: 4 cycles.
  - LW: 5 cycles.
- Each wait cycle adds 1 cycle to the instruction.
- instr_done is high exactly once per instruction, in the last cycle.
- mem_ready is ignored outside the three request states.

## Test plan
- **ADD** (opcode 0, funct 100000), mem_ready always 1 → states 0, 1, 6, 7. RTEXE shows alu_control=0000. RTWB shows reg_write=1, reg_dst=01. instr_done pulses in cycle 4.
- **LW** with mem_ready low for 2 cycles in MEMRD → states 0, 1, 2, 3, 3, 3, 4 (7 cycles). MEMWB shows mem_to_reg=01, reg_write=1.
- **BNE**, both zero values: zero=1 → pc_write=0 in BRANCH; zero=0 → pc_write=1 with pc_src=01. Both retire in 3 cycles.
- **JAL** → JAL state shows pc_write=1, reg_write=1, reg_dst=10, mem_to_reg=10. **JR** (funct 001000) → state 12 with pc_src=11.
- **Illegal opcode 111111** → FAULT (state 15, fault=1) after DECODE. The sequencer stays there through 10 cycles, then returns to FETCH after a rst_n pulse.
- **WAIT_LIMIT=4, mem_ready held low in FETCH** → FAULT after 4 wait cycles. Asserting rst_n low mid-SW in MEMWR drops mem_req/mem_we within the same cycle.
